// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing g_NRegs 8-bit registers behind an auto-incrementing pointer.
// Latency: pad to internal edge 3 Clk_ik (5 with I2C_TARGET_GLITCH_FILTER_EN); SDA drive 1 Clk_ik after internal SCL fall.
// Backpressure: none; SCL is never stretched and every byte is accepted and ACKed once the address matches.
module i2c_target_regfile #(
    parameter logic [6:0] g_Address = 7'h20,
    parameter int         g_NRegs   = 16,
    parameter int         g_PtrW    = $clog2(g_NRegs)
) (
    input  logic                   Clk_ik,
    input  logic                   Rst_irq,
    input  logic                   Scl_i,
    inout  wire                    Sda_ioz,
    output logic [8*g_NRegs-1:0]   Regs_ob,
    output logic                   WrStrobe_o,
    output logic [g_PtrW-1:0]      WrAddr_ob,
    output logic                   Busy_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    logic [1:0]        r_scl_sync;
    logic [1:0]        r_sda_sync;
    logic              w_scl;
    logic              w_sda;
    logic              r_scl_d;
    logic              r_sda_d;
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_sda_rise;
    logic              w_sda_fall;
    logic              w_start;
    logic              w_stop;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [g_PtrW-1:0] r_ptr;
    logic [g_PtrW-1:0] w_ptr_nxt;
    logic [g_PtrW-1:0] w_ptr_inc;
    logic              r_sda_oe;
    logic              w_sda_oe_nxt;
    logic              r_rw;
    logic              w_rw_nxt;
    logic              r_mack;
    logic              w_mack_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              w_wr_en;
    logic [7:0]        w_wr_dat;
    logic [7:0]        w_rd_cur;
    logic [7:0]        w_rd_nxt;
    logic              r_wr_stb;
    logic [g_PtrW-1:0] r_wr_addr;
    logic [7:0]        r_regs [g_NRegs];

    // Open-drain SDA: only ever pull low or release.
    assign Sda_ioz = r_sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers; reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge Clk_ik or posedge Rst_irq) begin
        if (Rst_irq) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], Scl_i};
            r_sda_sync <= {r_sda_sync[0], Sda_ioz};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] r_scl_flt;
    logic [2:0] r_sda_flt;

    // Three-sample history; a single-cycle pulse never wins the majority vote.
    always_ff @(posedge Clk_ik or posedge Rst_irq) begin
        if (Rst_irq) begin
            r_scl_flt <= 3'b111;
            r_sda_flt <= 3'b111;
        end else begin
            r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[1]};
            r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[1]};
        end
    end

    assign w_scl = (r_scl_flt[0] & r_scl_flt[1]) | (r_scl_flt[0] & r_scl_flt[2]) | (r_scl_flt[1] & r_scl_flt[2]);
    assign w_sda = (r_sda_flt[0] & r_sda_flt[1]) | (r_sda_flt[0] & r_sda_flt[2]) | (r_sda_flt[1] & r_sda_flt[2]);
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous conditioned levels for edge detection.
    always_ff @(posedge Clk_ik or posedge Rst_irq) begin
        if (Rst_irq) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_sda_rise = w_sda & ~r_sda_d;
    assign w_sda_fall = ~w_sda & r_sda_d;
    // START/STOP require SCL to have been high on both sides of the SDA edge.
    assign w_start    = w_sda_fall & w_scl & r_scl_d;
    assign w_stop     = w_sda_rise & w_scl & r_scl_d;

    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_wr_dat   = {r_shift[6:0], w_sda};
    assign w_rd_cur   = r_regs[r_ptr];
    assign w_rd_nxt   = r_regs[w_ptr_inc];

    // Next-state and datapath decode; START/STOP override every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_sda_oe_nxt = r_sda_oe;
        w_rw_nxt     = r_rw;
        w_mack_nxt   = r_mack;
        w_busy_nxt   = r_busy;
        w_wr_en      = 1'b0;
        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise && (r_cnt < 4'd8)) begin
                        w_shift_nxt = w_wr_dat;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if ((r_state == S_WDATA) && (r_cnt == 4'd7)) begin
                            w_wr_en   = 1'b1;
                            w_ptr_nxt = w_ptr_inc;
                        end
                    end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == g_Address) begin
                                w_state_nxt  = S_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_rw_nxt     = r_shift[0];
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end else if (r_state == S_PTR) begin
                            w_ptr_nxt    = r_shift[g_PtrW-1:0];
                            w_state_nxt  = S_PTR_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = S_WDATA_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_shift_nxt  = w_rd_cur;
                            w_sda_oe_nxt = ~w_rd_cur[7];
                            w_state_nxt  = S_RDATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt    = 4'd0;
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && (r_cnt < 4'd8)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_RDATA_ACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        w_cnt_nxt = 4'd0;
                        if (r_mack) begin
                            w_ptr_nxt    = w_ptr_inc;
                            w_shift_nxt  = w_rd_nxt;
                            w_sda_oe_nxt = ~w_rd_nxt[7];
                            w_state_nxt  = S_RDATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
                default: begin
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge Clk_ik or posedge Rst_irq) begin
        if (Rst_irq) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_rw      <= w_rw_nxt;
            r_mack    <= w_mack_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_stb  <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
            end
        end
    end

    // Register bank, written on the last data bit of each received byte.
    always_ff @(posedge Clk_ik or posedge Rst_irq) begin
        if (Rst_irq) begin
            for (int k = 0; k < g_NRegs; k++) begin
                r_regs[k] <= 8'h00;
            end
        end else if (w_wr_en) begin
            r_regs[r_ptr] <= w_wr_dat;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < g_NRegs; gi++) begin : g_regs_out
            assign Regs_ob[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    assign WrStrobe_o = r_wr_stb;
    assign WrAddr_ob  = r_wr_addr;
    assign Busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master driving the register-file target.
// Latency: bit-level master with 32 Clk_ik per SCL period.
// Backpressure: not applicable; master paces all traffic.
module tb_i2c_target_regfile;
    localparam int NREGS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 scl;
    logic                 m_low;
    wire                  sda;
    logic [8*NREGS-1:0]   regs;
    logic                 wr_stb;
    logic [3:0]           wr_addr;
    logic                 busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target_regfile #(.g_Address(7'h20), .g_NRegs(NREGS)) dut (
        .Clk_ik     (clk),
        .Rst_irq    (rst),
        .Scl_i      (scl),
        .Sda_ioz    (sda),
        .Regs_ob    (regs),
        .WrStrobe_o (wr_stb),
        .WrAddr_ob  (wr_addr),
        .Busy_o     (busy)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] stb_log [$];
    logic       ack;
    logic       s;
    logic [7:0] d;
    logic [7:0] glitch_exp;

    // Record every write strobe with its address.
    always @(negedge clk) begin
        if (wr_stb) stb_log.push_back(wr_addr);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drv, output logic smp);
        m_low = ~drv;
        wclk(8);
        scl = 1'b1;
        wclk(8);
        smp = sda;
        wclk(8);
        scl = 1'b0;
        wclk(8);
    endtask

    task automatic i2c_start;
        m_low = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        m_low = 1'b1;
        wclk(8);
        scl = 1'b0;
        wclk(8);
    endtask

    task automatic i2c_stop;
        m_low = 1'b1;
        wclk(8);
        scl = 1'b1;
        wclk(8);
        m_low = 1'b0;
        wclk(16);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        logic sm;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], sm);
        clock_bit(1'b1, sm);
        a = ~sm;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] dat);
        logic sm;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, sm);
            dat[i] = sm;
        end
        clock_bit(~give_ack, sm);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        glitch_exp = 8'h81;
`else
        glitch_exp = 8'hC0;
`endif
        rst = 1'b1; scl = 1'b1; m_low = 1'b0;
        wclk(4);
        check("rst_regs", regs, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_wraddr", wr_addr, 4'd0);
        check("rst_sda", sda, 1'b1);
        rst = 1'b0;
        wclk(8);

        // Write two bytes at pointer 3
        i2c_start;
        send_byte(8'h40, ack); check("wr_addr_ack", ack, 1'b1);
        check("wr_busy", busy, 1'b1);
        send_byte(8'h03, ack); check("wr_ptr_ack", ack, 1'b1);
        send_byte(8'hA5, ack); check("wr_d0_ack", ack, 1'b1);
        send_byte(8'h5A, ack); check("wr_d1_ack", ack, 1'b1);
        i2c_stop;
        check("wr_reg3", regs[8*3 +: 8], 8'hA5);
        check("wr_reg4", regs[8*4 +: 8], 8'h5A);
        check("wr_stb_cnt", stb_log.size(), 2);
        check("wr_stb_a0", stb_log[0], 4'd3);
        check("wr_stb_a1", stb_log[1], 4'd4);
        check("wr_busy_stop", busy, 1'b0);

        // Read back with repeated START
        i2c_start;
        send_byte(8'h40, ack); check("rd_waddr_ack", ack, 1'b1);
        send_byte(8'h03, ack); check("rd_ptr_ack", ack, 1'b1);
        i2c_start;
        send_byte(8'h41, ack); check("rd_raddr_ack", ack, 1'b1);
        read_byte(1'b1, d); check("rd_d0", d, 8'hA5);
        read_byte(1'b0, d); check("rd_d1", d, 8'h5A);
        check("rd_sda_rel", sda, 1'b1);
        i2c_stop;
        check("rd_busy_stop", busy, 1'b0);
        check("rd_no_stb", stb_log.size(), 2);

        // Read continues at the pointer left by the previous write
        i2c_start; send_byte(8'h40, ack); send_byte(8'h08, ack); send_byte(8'h96, ack); i2c_stop;
        i2c_start; send_byte(8'h40, ack); send_byte(8'h07, ack); send_byte(8'hC3, ack); i2c_stop;
        i2c_start;
        send_byte(8'h41, ack); check("cont_addr_ack", ack, 1'b1);
        read_byte(1'b0, d); check("cont_d", d, 8'h96);
        i2c_stop;
        check("cont_reg7", regs[8*7 +: 8], 8'hC3);

        // Address mismatch
        i2c_start;
        send_byte(8'h44, ack); check("mm_nack", ack, 1'b0);
        check("mm_busy", busy, 1'b0);
        send_byte(8'h00, ack); check("mm_b1_nack", ack, 1'b0);
        send_byte(8'hFF, ack); check("mm_b2_nack", ack, 1'b0);
        check("mm_busy2", busy, 1'b0);
        i2c_stop;
        check("mm_stb_cnt", stb_log.size(), 4);
        check("mm_reg0", regs[8*0 +: 8], 8'h00);
        check("mm_reg3", regs[8*3 +: 8], 8'hA5);

        // Pointer upper bits ignored
        i2c_start; send_byte(8'h40, ack); send_byte(8'h1F, ack); send_byte(8'h77, ack); i2c_stop;
        check("p1f_reg15", regs[8*15 +: 8], 8'h77);
        check("p1f_stb", stb_log[4], 4'd15);

        // Pointer wraps modulo 16
        i2c_start; send_byte(8'h40, ack); send_byte(8'h0F, ack); send_byte(8'h11, ack); send_byte(8'h22, ack); i2c_stop;
        check("wrap_reg15", regs[8*15 +: 8], 8'h11);
        check("wrap_reg0", regs[8*0 +: 8], 8'h22);
        check("wrap_stb", stb_log[6], 4'd0);

        // One-cycle low glitch on SCL during the first data bit (0x81)
        i2c_start; send_byte(8'h40, ack); send_byte(8'h06, ack);
        m_low = 1'b0;
        wclk(8); scl = 1'b1; wclk(6); scl = 1'b0; wclk(1); scl = 1'b1; wclk(9); scl = 1'b0; wclk(8);
        d = 8'h81;
        for (int i = 6; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        i2c_stop;
        check("glitch_reg6", regs[8*6 +: 8], glitch_exp);
        check("glitch_stb_cnt", stb_log.size(), 8);

        // Reset asserted mid-byte while the target drives a 0 bit
        i2c_start;
        send_byte(8'h40, ack); send_byte(8'h03, ack);
        i2c_start;
        send_byte(8'h41, ack); check("rst_rd_ack", ack, 1'b1);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        m_low = 1'b0; wclk(8); scl = 1'b1; wclk(8);
        check("rst_bit4_low", sda, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_sda_rel", sda, 1'b1);
        @(negedge clk);
        check("rst_mid_regs", regs, '0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_wraddr", wr_addr, 4'd0);
        wclk(3);
        rst = 1'b0;
        wclk(4);
        scl = 1'b0;
        wclk(8);
        i2c_stop;
        i2c_start;
        send_byte(8'h40, ack); check("post_addr_ack", ack, 1'b1);
        send_byte(8'h01, ack); check("post_ptr_ack", ack, 1'b1);
        send_byte(8'h3C, ack); check("post_d_ack", ack, 1'b1);
        i2c_stop;
        check("post_regs", regs, {112'h0, 8'h3C, 8'h00});
        check("post_stb", stb_log[8], 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
